turbo_encoder: RTL
==================

// Module: turbo_encoder
// PURPOSE
// - Rate-1/3 parallel-concatenated turbo encoder: the transmit-side counterpart of the Decoder.
// - Accepts one 5-bit message per block and appends 2'b00 to form the 7-bit extended block u[6:0].
// - Encodes u bit-serially through two RSC(1,5/7) encoders; RSC2 sees the interleaved sequence.
// - Emits one 21-bit word {sys, par1, par2}, or its 84-bit soft image, in the layout the Decoder reads.
// PARAMETERS
// - INPUT_SIZE   5     message bits per block
// - EXTEND_SIZE  7     INPUT_SIZE + 2 zero tail bits
// - BLOCK_SIZE   21    3*EXTEND_SIZE output bits
// - ITL_STEP     3     interleaver v[k] = u[(ITL_STEP*k) mod EXTEND_SIZE]; must be coprime with 7
// - SOFT_POS     4'h7  soft value for bit 1 (used only with TURBO_ENC_SOFT_EN)
// - SOFT_NEG     4'h9  soft value for bit 0 (used only with TURBO_ENC_SOFT_EN)
// PORTS
// - clk_p_i      in   1        clock; all logic on rising edge
// - reset_i      in   1        synchronous, active-high reset
// - in_valid_i   in   1        message valid
// - in_ready_o   out  1        encoder can accept a message
// - in_data_i    in   5        message; in_data_i[0] = u[0] is encoded first
// - out_valid_o  out  1        data_o holds a complete block
// - out_ready_i  in   1        sink accepts the block
// - data_o       out  OUT_W    OUT_W = 21, or 84 with TURBO_ENC_SOFT_EN
// - busy_o       out  1        high in ENC and OUT states
// BEHAVIOUR
// - Reset: state=IDLE; in_ready_o=1; out_valid_o=0; data_o=0; busy_o=0; counter, RSC states and shift regs=0.
// - Reset asserted in any state aborts the block in flight; nothing is emitted for it.
// - FSM IDLE -> ENC -> OUT -> IDLE. in_ready_o = (state==IDLE); input handshake = in_valid_i & in_ready_o.
// - IDLE: on handshake, latch u = {2'b00, in_data_i}; clear k, both RSC states and par regs; go to ENC.
// - ENC: runs exactly 7 cycles, k = 0..6. Each cycle both encoders advance one step:
//     RSC1 input x = u[k]; RSC2 input x = u[(ITL_STEP*k)%7] (constant lookup table, no divider).
//     Step for each encoder: a = x^s1^s2; p = a^s2; s2 <= s1; s1 <= a.
//     par1[k] <= p(RSC1); par2[k] <= p(RSC2); sys[k] = u[k].
//     At k==6 go to OUT; the trellis is not terminated (the zero tail only pads the block).
// - OUT: out_valid_o=1; data_o = {sys[6:0], par1[6:0], par2[6:0]}, i.e. sys in [20:14], par1 in [13:7], par2 in [6:0].
//     data_o is stable while out_valid_o & ~out_ready_i.
//     On out_ready_i go to IDLE; out_valid_o drops the next cycle and data_o keeps its last value.
// - Latency: input handshake in cycle 0; ENC in cycles 1-7; out_valid_o high from cycle 8.
//     With out_ready_i tied high, throughput is one block per 9 cycles.
// - in_valid_i outside IDLE is ignored; no input is queued or dropped silently, because ready=0 blocks it.
// - out_ready_i without out_valid_o has no effect.
// CONFIGURATION
// - Macro TURBO_ENC_SOFT_EN defined:
//     OUT_W=84; hard bit b_i (i=0..20) maps to data_o[4i+3:4i] = b_i ? SOFT_POS : SOFT_NEG.
//     The result drives the Decoder data_i input directly. Mapping is combinational from the held hard word.
// - Macro undefined: OUT_W=21; data_o is the hard word; SOFT_POS and SOFT_NEG are unused.
// TESTING
// - All-zero message: in_data_i=5'h00 -> data_o=21'h000000 at cycle 8 (soft: 84 bits, all 4'h9).
// - Impulse: in_data_i=5'h01 -> sys=7'h01, par1=7'h37, par2=7'h37, so data_o=21'h005BB7.
// - Backpressure: hold out_ready_i=0 for 5 cycles -> out_valid_o stays 1, data_o unchanged, in_ready_o=0;
//     release -> handshake, then IDLE.
// - Busy input: pulse in_valid_i with 5'h1F during ENC -> ignored; the output matches the earlier message.
// - Reset mid-ENC (k=3): reset_i high for 1 cycle -> next cycle in_ready_o=1, out_valid_o=0, data_o=0;
//     no block is emitted.
// - Random: 1000 messages with random ready/valid gaps -> every block matches a C/Python model
//     (RSC 1,5/7 with the ITL_STEP=3 interleaver); the output count equals the accepted input count.

Source files
------------

// File: rtl/turbo_encoder.sv
// Rate-1/3 turbo encoder: two RSC(1,5/7) encoders, RSC2 fed through a step interleaver.
// Optional soft output image enabled by macro TURBO_ENC_SOFT_EN.
module turbo_encoder #(
   parameter int INPUT_SIZE  = 5,
   parameter int EXTEND_SIZE = 7,
   parameter int BLOCK_SIZE  = 21,
`ifdef TURBO_ENC_SOFT_EN
   parameter logic [3:0] SOFT_POS = 4'h7,
   parameter logic [3:0] SOFT_NEG = 4'h9,
`endif
   parameter int ITL_STEP    = 3
) (
   input  logic                  clk_p_i,
   input  logic                  reset_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [INPUT_SIZE-1:0] in_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
`ifdef TURBO_ENC_SOFT_EN
   output logic [4*BLOCK_SIZE-1:0] data_o,
`else
   output logic [BLOCK_SIZE-1:0]   data_o,
`endif
   output logic                  busy_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENC,
      S_OUT
   } state_t;

   state_t                 r_state;
   logic [EXTEND_SIZE-1:0] r_u;
   logic [2:0]             r_k;
   logic                   r_s1a;
   logic                   r_s2a;
   logic                   r_s1b;
   logic                   r_s2b;
   logic [EXTEND_SIZE-1:0] r_par1;
   logic [EXTEND_SIZE-1:0] r_par2;
   logic [BLOCK_SIZE-1:0]  r_word;
   logic                   r_in_ready;
   logic                   r_out_valid;
   logic                   r_busy;

   logic [2:0]             w_itl [8];
   logic [EXTEND_SIZE-1:0] w_sel1;
   logic [EXTEND_SIZE-1:0] w_sel2;
   logic                   w_x1;
   logic                   w_x2;
   logic                   w_a1;
   logic                   w_a2;
   logic                   w_p1;
   logic                   w_p2;
   logic [EXTEND_SIZE-1:0] w_par1_nxt;
   logic [EXTEND_SIZE-1:0] w_par2_nxt;
   logic                   w_in_hs;
   logic                   w_last;

   // Interleaver lookup: constant table, index 7 is never reached
   for (genvar g = 0; g < 8; g++) begin : g_itl
      if (g < EXTEND_SIZE) begin : g_on
         assign w_itl[g] = 3'((ITL_STEP * g) % EXTEND_SIZE);
      end else begin : g_off
         assign w_itl[g] = 3'd0;
      end
   end

   assign w_in_hs = in_valid_i & r_in_ready;
   assign w_last  = (r_k == 3'(EXTEND_SIZE - 1));

   // One trellis step of both RSC encoders for the current k
   always_comb begin
      w_sel1     = EXTEND_SIZE'(1) << r_k;
      w_sel2     = EXTEND_SIZE'(1) << w_itl[r_k];
      w_x1       = |(r_u & w_sel1);
      w_x2       = |(r_u & w_sel2);
      w_a1       = w_x1 ^ r_s1a ^ r_s2a;
      w_a2       = w_x2 ^ r_s1b ^ r_s2b;
      w_p1       = w_a1 ^ r_s2a;
      w_p2       = w_a2 ^ r_s2b;
      w_par1_nxt = r_par1;
      w_par2_nxt = r_par2;
      if (w_p1) w_par1_nxt = r_par1 | w_sel1;
      if (w_p2) w_par2_nxt = r_par2 | w_sel1;
   end

   // Block FSM with registered handshake, busy and output word
   always_ff @(posedge clk_p_i) begin
      if (reset_i) begin
         r_state     <= S_IDLE;
         r_u         <= '0;
         r_k         <= '0;
         r_s1a       <= 1'b0;
         r_s2a       <= 1'b0;
         r_s1b       <= 1'b0;
         r_s2b       <= 1'b0;
         r_par1      <= '0;
         r_par2      <= '0;
         r_word      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_in_hs) begin
                  r_u        <= {{(EXTEND_SIZE-INPUT_SIZE){1'b0}}, in_data_i};
                  r_k        <= '0;
                  r_s1a      <= 1'b0;
                  r_s2a      <= 1'b0;
                  r_s1b      <= 1'b0;
                  r_s2b      <= 1'b0;
                  r_par1     <= '0;
                  r_par2     <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_ENC;
               end
            end
            S_ENC: begin
               r_s2a  <= r_s1a;
               r_s1a  <= w_a1;
               r_s2b  <= r_s1b;
               r_s1b  <= w_a2;
               r_par1 <= w_par1_nxt;
               r_par2 <= w_par2_nxt;
               r_k    <= r_k + 3'd1;
               if (w_last) begin
                  r_word      <= {r_u, w_par1_nxt, w_par2_nxt};
                  r_out_valid <= 1'b1;
                  r_state     <= S_OUT;
               end
            end
            S_OUT: begin
               if (out_ready_i) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b1;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o  = r_in_ready;
   assign out_valid_o = r_out_valid;
   assign busy_o      = r_busy;

`ifdef TURBO_ENC_SOFT_EN
   for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_soft
      assign data_o[4*i +: 4] = r_word[i] ? SOFT_POS : SOFT_NEG;
   end
`else
   assign data_o = r_word;
`endif

endmodule
